// File: rtl/bky_pkg.sv
// Shared constants, FSM state encoding and counter-width helper for the
// Buckeye configuration shift controller.
package bky_pkg;

   localparam int BKY_NCHIPS  = 6;
   localparam int BKY_NBITS   = 48;
   localparam int BKY_CLK_DIV = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_FINISH
   } bky_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/buckeye_shift_ctrl_if.sv
// Request/readback bundle between the user register logic, the controller
// and the Buckeye pad buffers.
interface buckeye_shift_ctrl_if
   import bky_pkg::*;
#(
   parameter int NCHIPS = BKY_NCHIPS,
   parameter int NBITS  = BKY_NBITS
);
   logic                      START;
   logic [NCHIPS-1:0]         CHIP_MASK;
   logic [NCHIPS*NBITS-1:0]   DIN;
   logic [NCHIPS-1:0]         BKY_RTN;
   logic [NCHIPS-1:0]         TO_BKY;
   logic [NCHIPS-1:0]         BKY_CLK;
   logic [NCHIPS*NBITS-1:0]   DOUT;
   logic                      BUSY;
   logic                      DONE;
   logic [NCHIPS-1:0]         CMP_ERR;

   modport master (
      output START, CHIP_MASK, DIN, BKY_RTN,
      input  TO_BKY, BKY_CLK, DOUT, BUSY, DONE, CMP_ERR
   );

   modport slave (
      input  START, CHIP_MASK, DIN, BKY_RTN,
      output TO_BKY, BKY_CLK, DOUT, BUSY, DONE, CMP_ERR
   );
endinterface

// File: rtl/bky_phase_timer.sv
// Free-running phase counter: strobes o_phase_end on the last cycle of every
// CLK_DIV-cycle BKY_CLK phase; i_restart realigns it to a fresh phase.
module bky_phase_timer
   import bky_pkg::*;
#(
   parameter int CLK_DIV = BKY_CLK_DIV
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_restart,
   output logic o_phase_end
);
   localparam int            W    = cnt_width(CLK_DIV);
   localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge CLK) begin
      if (RST || i_restart) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_phase_end = (r_cnt == LAST);

endmodule

// File: rtl/buckeye_shift_ctrl.sv
// Serial loader for the Buckeye shaper configuration registers: shifts DIN out
// MSB-first on every enabled lane while capturing the old contents from BKY_RTN.
module buckeye_shift_ctrl
   import bky_pkg::*;
#(
   parameter int NCHIPS  = BKY_NCHIPS,
   parameter int NBITS   = BKY_NBITS,
   parameter int CLK_DIV = BKY_CLK_DIV
) (
   input logic                  CLK,
   input logic                  RST,
   buckeye_shift_ctrl_if.slave  bus
);
   localparam int             BW       = cnt_width(NBITS);
   localparam logic [BW-1:0]  LAST_BIT = BW'(NBITS - 1);

   bky_state_t         r_state;
   bky_state_t         w_state_next;
   logic [BW-1:0]      r_bit_cnt;
   logic [NCHIPS-1:0]  r_mask;
   logic               r_busy;
   logic               r_done;

   logic w_phase_end;
   logic w_load;
   logic w_shift;
   logic w_bit_end;
   logic w_last_bit;
   logic w_enter_low;
   logic w_enter_finish;

   bky_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .CLK         (CLK),
      .RST         (RST),
      .i_restart   (w_load),
      .o_phase_end (w_phase_end)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (bus.START) w_state_next = ST_LOW;
         ST_LOW:    if (w_phase_end) w_state_next = ST_HIGH;
         ST_HIGH:   if (w_phase_end) w_state_next = w_last_bit ? ST_FINISH : ST_LOW;
         ST_FINISH: w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_load         = 1'b0;
      w_shift        = 1'b0;
      w_bit_end      = 1'b0;
      w_last_bit     = (r_bit_cnt == LAST_BIT);
      w_enter_low    = 1'b0;
      w_enter_finish = 1'b0;
      case (r_state)
         ST_IDLE: w_load  = bus.START;
         ST_LOW:  w_shift = w_phase_end;
         ST_HIGH: begin
            w_bit_end      = w_phase_end;
            w_enter_low    = w_phase_end & ~w_last_bit;
            w_enter_finish = w_phase_end &  w_last_bit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bit_cnt <= '0;
         r_mask    <= '0;
      end else begin
         r_done <= w_enter_finish;
         if (w_load) begin
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_mask    <= bus.CHIP_MASK;
         end else begin
            if (r_state == ST_FINISH) r_busy <= 1'b0;
            if (w_enter_low) r_bit_cnt <= r_bit_cnt + BW'(1);
         end
      end
   end

   assign bus.BUSY = r_busy;
   assign bus.DONE = r_done;

   genvar gi;
   generate
      for (gi = 0; gi < NCHIPS; gi++) begin : g_lane
         logic [NBITS-1:0] r_shift;
         logic [NBITS-1:0] r_din;
         logic [NBITS-1:0] r_cap;
         logic [NBITS-1:0] r_dout;
         logic             r_to_bky;
         logic             r_bky_clk;
         logic             r_cmp_err;

         // TO_BKY is its own register so it stays put while the shift
         // register advances at the start of the high phase.
         always_ff @(posedge CLK) begin
            if (RST) begin
               r_shift   <= '0;
               r_din     <= '0;
               r_cap     <= '0;
               r_dout    <= '0;
               r_to_bky  <= 1'b0;
               r_bky_clk <= 1'b0;
               r_cmp_err <= 1'b0;
            end else begin
               if (w_load) begin
                  r_shift  <= bus.DIN[gi*NBITS +: NBITS];
                  r_din    <= bus.DIN[gi*NBITS +: NBITS];
                  r_cap    <= '0;
                  r_to_bky <= bus.DIN[gi*NBITS + NBITS - 1] & bus.CHIP_MASK[gi];
               end else if (w_shift) begin
                  r_shift <= {r_shift[NBITS-2:0], 1'b0};
                  r_cap   <= {r_cap[NBITS-2:0], bus.BKY_RTN[gi]};
               end else if (w_enter_low) begin
                  r_to_bky <= r_shift[NBITS-1] & r_mask[gi];
               end else if (w_enter_finish) begin
                  r_to_bky  <= 1'b0;
                  r_dout    <= r_mask[gi] ? r_cap : '0;
                  r_cmp_err <= r_mask[gi] & (r_cap != r_din);
               end

               if (w_shift) begin
                  r_bky_clk <= r_mask[gi];
               end else if (w_bit_end) begin
                  r_bky_clk <= 1'b0;
               end
            end
         end

         assign bus.TO_BKY[gi]                = r_to_bky;
         assign bus.BKY_CLK[gi]               = r_bky_clk;
         assign bus.CMP_ERR[gi]               = r_cmp_err;
         assign bus.DOUT[gi*NBITS +: NBITS]   = r_dout;
      end
   endgenerate

endmodule

// File: tb/tb_buckeye_shift_ctrl.sv
// Self-checking bench for buckeye_shift_ctrl: table of load vectors against
// looped-back chip models, plus hand-written timing, abort and zero-mask runs.
module tb_buckeye_shift_ctrl;
   import bky_pkg::*;

   localparam int NC    = 6;
   localparam int NB    = 48;
   localparam int LIMIT = 2000;
   localparam int LAT2  = 2*2*NB + 1;
   localparam int LAT3  = 2*3*NB + 1;
   localparam int LAT1  = 2*1*NB + 1;

   typedef struct {
      logic [NC-1:0] mask;
      logic [NB-1:0] base;
      logic [NC-1:0] exp_cmp;
   } vec_t;

   typedef struct {
      logic [NC*NB-1:0] dout;
      logic [NC-1:0]    cmp;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   logic chip_clr;

   int n_cmp = 0;
   int n_err = 0;

   exp_t          sb_q[$];
   logic [NB-1:0] exp_chip [NC];
   vec_t          vecs [5];

   int            rise_cnt [NC];
   int            to_hi_cnt [NC];
   int            done_cnt;
   logic [NC-1:0] clk_prev;

   always #5 CLK = ~CLK;

   buckeye_shift_ctrl_if #(.NCHIPS(NC), .NBITS(NB)) bus2 ();
   buckeye_shift_ctrl_if #(.NCHIPS(NC), .NBITS(NB)) bus3 ();
   buckeye_shift_ctrl_if #(.NCHIPS(NC), .NBITS(NB)) bus1 ();

   buckeye_shift_ctrl #(.NCHIPS(NC), .NBITS(NB), .CLK_DIV(2)) u_dut2 (
      .CLK (CLK), .RST (RST), .bus (bus2));
   buckeye_shift_ctrl #(.NCHIPS(NC), .NBITS(NB), .CLK_DIV(3)) u_dut3 (
      .CLK (CLK), .RST (RST), .bus (bus3));
   buckeye_shift_ctrl #(.NCHIPS(NC), .NBITS(NB), .CLK_DIV(1)) u_dut1 (
      .CLK (CLK), .RST (RST), .bus (bus1));

   // Chip models: each lane is a 48-bit shift register clocked by its BKY_CLK.
   genvar gi;
   generate
      for (gi = 0; gi < NC; gi++) begin : g_chip
         logic [NB-1:0] q;
         always @(posedge bus2.BKY_CLK[gi] or posedge chip_clr) begin
            if (chip_clr) q <= '0;
            else          q <= {q[NB-2:0], bus2.TO_BKY[gi]};
         end
         assign bus2.BKY_RTN[gi] = q[NB-1];
      end
   endgenerate

   initial begin
      done_cnt = 0;
      clk_prev = '0;
      for (int k = 0; k < NC; k++) begin
         rise_cnt[k]  = 0;
         to_hi_cnt[k] = 0;
      end
   end

   always @(negedge CLK) begin
      for (int k = 0; k < NC; k++) begin
         if (bus2.BKY_CLK[k] === 1'b1 && clk_prev[k] !== 1'b1) rise_cnt[k] <= rise_cnt[k] + 1;
         if (bus2.TO_BKY[k] === 1'b1) to_hi_cnt[k] <= to_hi_cnt[k] + 1;
      end
      clk_prev <= bus2.BKY_CLK;
      if (bus2.DONE === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string name, input logic [NC*NB-1:0] act,
                        input logic [NC*NB-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start2(input logic [NC-1:0] mask, input logic [NC*NB-1:0] din);
      @(negedge CLK);
      bus2.CHIP_MASK = mask;
      bus2.DIN       = din;
      bus2.START     = 1'b1;
      @(negedge CLK);
      bus2.START     = 1'b0;
      // Inputs scrambled while busy must not disturb the run.
      bus2.CHIP_MASK = ~mask;
      bus2.DIN       = ~din;
   endtask

   task automatic wait_done2(inout int cyc);
      while (bus2.DONE !== 1'b1 && cyc < LIMIT) begin
         @(negedge CLK);
         cyc++;
      end
   endtask

   task automatic build_din(input logic [NB-1:0] base, output logic [NC*NB-1:0] din);
      for (int k = 0; k < NC; k++) din[k*NB +: NB] = base + NB'(k);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [NC*NB-1:0] din;
      exp_t             e;
      int               cyc;
      int               r0 [NC];
      int               t0 [NC];
      int               d0;
      build_din(v.base, din);
      for (int k = 0; k < NC; k++) e.dout[k*NB +: NB] = v.mask[k] ? exp_chip[k] : '0;
      e.cmp = v.exp_cmp;
      sb_q.push_back(e);
      for (int k = 0; k < NC; k++) begin
         r0[k] = rise_cnt[k];
         t0[k] = to_hi_cnt[k];
      end
      d0 = done_cnt;
      start2(v.mask, din);
      cyc = 1;
      wait_done2(cyc);
      check({tag, " latency"}, cyc, LAT2);
      e = sb_q.pop_front();
      check({tag, " dout"}, bus2.DOUT, e.dout);
      check({tag, " cmp_err"}, bus2.CMP_ERR, e.cmp);
      for (int k = 0; k < NC; k++) if (v.mask[k]) exp_chip[k] = din[k*NB +: NB];
      repeat (3) @(negedge CLK);
      check({tag, " busy_after"}, bus2.BUSY, 1'b0);
      check({tag, " done_pulses"}, done_cnt - d0, 1);
      for (int k = 0; k < NC; k++) begin
         check($sformatf("%s rises lane%0d", tag, k), rise_cnt[k] - r0[k], v.mask[k] ? NB : 0);
         if (!v.mask[k]) check($sformatf("%s to_bky lane%0d", tag, k), to_hi_cnt[k] - t0[k], 0);
      end
      $display("txn %s: mask=%h latency=%0d cmp_err=%h", tag, v.mask, cyc, bus2.CMP_ERR);
   endtask

   initial begin
      logic [NC*NB-1:0] din;
      logic [NC*NB-1:0] din_b;
      exp_t             e;
      int               cyc;
      int               d0;
      int               n_clk_bad;
      int               n_to_bad;
      int               n_oth_bad;
      int               busy_cnt;
      int               done_seen;

      vecs[0] = '{6'h3F, 48'hA5A5_0000_0000, 6'h3F};
      vecs[1] = '{6'h3F, 48'hA5A5_0000_0000, 6'h00};
      vecs[2] = '{6'h15, 48'h1234_5678_9AB0, 6'h15};
      vecs[3] = '{6'h15, 48'h1234_5678_9AB0, 6'h00};
      vecs[4] = '{6'h3F, 48'hFFFF_0000_FFF0, 6'h3F};

      RST = 1'b1;
      chip_clr = 1'b0;
      bus2.START = 1'b0; bus2.CHIP_MASK = '0; bus2.DIN = '0;
      bus3.START = 1'b0; bus3.CHIP_MASK = '0; bus3.DIN = '0; bus3.BKY_RTN = '0;
      bus1.START = 1'b0; bus1.CHIP_MASK = '0; bus1.DIN = '0; bus1.BKY_RTN = '0;
      for (int k = 0; k < NC; k++) exp_chip[k] = '0;
      #1 chip_clr = 1'b1;
      #1 chip_clr = 1'b0;
      repeat (3) @(negedge CLK);

      check("rst busy", bus2.BUSY, 1'b0);
      check("rst done", bus2.DONE, 1'b0);
      check("rst dout", bus2.DOUT, '0);
      check("rst cmp_err", bus2.CMP_ERR, '0);
      check("rst bky_clk", bus2.BKY_CLK, '0);
      check("rst to_bky", bus2.TO_BKY, '0);

      // START coincident with RST must be dropped.
      bus2.START = 1'b1; bus2.CHIP_MASK = 6'h3F;
      @(negedge CLK);
      RST = 1'b0; bus2.START = 1'b0;
      @(negedge CLK);
      check("start_with_rst busy", bus2.BUSY, 1'b0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Second START at cycle 10 with different data is ignored.
      build_din(48'h0F0F_0F0F_0F00, din);
      build_din(48'h3333_3333_3300, din_b);
      for (int k = 0; k < NC; k++) e.dout[k*NB +: NB] = exp_chip[k];
      e.cmp = 6'h3F;
      sb_q.push_back(e);
      d0 = done_cnt;
      start2(6'h3F, din);
      cyc = 1;
      repeat (9) begin @(negedge CLK); cyc++; end
      bus2.DIN = din_b; bus2.CHIP_MASK = 6'h3F; bus2.START = 1'b1;
      @(negedge CLK); cyc++;
      bus2.START = 1'b0;
      wait_done2(cyc);
      check("busy_start latency", cyc, LAT2);
      e = sb_q.pop_front();
      check("busy_start dout", bus2.DOUT, e.dout);
      check("busy_start cmp_err", bus2.CMP_ERR, e.cmp);
      for (int k = 0; k < NC; k++) exp_chip[k] = din[k*NB +: NB];
      repeat (3) @(negedge CLK);
      check("busy_start no_requeue", bus2.BUSY, 1'b0);
      check("busy_start done_pulses", done_cnt - d0, 1);
      $display("txn busy_start: latency=%0d", cyc);

      // Abort at cycle 50 of a shift.
      build_din(48'h5A5A_1111_2220, din);
      start2(6'h3F, din);
      cyc = 1;
      while (cyc < 50) begin @(negedge CLK); cyc++; end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort busy", bus2.BUSY, 1'b0);
      check("abort bky_clk", bus2.BKY_CLK, '0);
      check("abort to_bky", bus2.TO_BKY, '0);
      check("abort dout", bus2.DOUT, '0);
      check("abort cmp_err", bus2.CMP_ERR, '0);
      d0 = done_cnt;
      repeat (200) @(negedge CLK);
      check("abort no_done", done_cnt - d0, 0);
      check("abort stays_idle", bus2.BUSY, 1'b0);
      $display("txn abort: reset at cycle %0d", cyc);
      chip_clr = 1'b1;
      #1 chip_clr = 1'b0;
      for (int k = 0; k < NC; k++) exp_chip[k] = '0;
      run_vec('{6'h3F, 48'hC3C3_3C3C_0000, 6'h3F}, "post_abort");

      // Bit timing on lane 0 with CLK_DIV=3.
      din = '0;
      din[NB-1:0] = 48'h8000_0000_0001;
      @(negedge CLK);
      bus3.CHIP_MASK = 6'h01; bus3.DIN = din; bus3.START = 1'b1;
      @(negedge CLK);
      bus3.START = 1'b0;
      n_clk_bad = 0; n_to_bad = 0; n_oth_bad = 0;
      for (int i = 1; i <= 2*3*NB; i++) begin
         if (i > 1) @(negedge CLK);
         if (bus3.BKY_CLK[0] !== (((i-1) % 6) >= 3)) n_clk_bad++;
         if (bus3.TO_BKY[0] !== ((((i-1) / 6) == 0) || (((i-1) / 6) == NB-1))) n_to_bad++;
         if (bus3.BKY_CLK[NC-1:1] !== '0 || bus3.TO_BKY[NC-1:1] !== '0) n_oth_bad++;
      end
      check("timing clk_phase_errors", n_clk_bad, 0);
      check("timing to_bky_errors", n_to_bad, 0);
      check("timing masked_lane_activity", n_oth_bad, 0);
      @(negedge CLK);
      check("timing done_at_289", bus3.DONE, 1'b1);
      check("timing finish bky_clk", bus3.BKY_CLK, '0);
      check("timing finish to_bky", bus3.TO_BKY, '0);
      check("timing dout", bus3.DOUT, '0);
      check("timing cmp_err", bus3.CMP_ERR, 6'h01);
      $display("txn timing: lane0 din=%h expected latency %0d", din[NB-1:0], LAT3);

      // Zero mask with CLK_DIV=1 still runs the full timing.
      @(negedge CLK);
      bus1.CHIP_MASK = '0; bus1.DIN = {NC{48'hFFFF_FFFF_FFFF}}; bus1.START = 1'b1;
      @(negedge CLK);
      bus1.START = 1'b0;
      busy_cnt = 0; done_seen = 0; n_clk_bad = 0;
      for (int i = 0; i < 150; i++) begin
         if (bus1.BUSY === 1'b1) busy_cnt++;
         if (bus1.DONE === 1'b1) done_seen++;
         if (bus1.BKY_CLK !== '0 || bus1.TO_BKY !== '0) n_clk_bad++;
         @(negedge CLK);
      end
      check("zero_mask busy_cycles", busy_cnt, LAT1);
      check("zero_mask done_pulses", done_seen, 1);
      check("zero_mask lane_activity", n_clk_bad, 0);
      check("zero_mask cmp_err", bus1.CMP_ERR, '0);
      $display("txn zero_mask: busy=%0d done=%0d", busy_cnt, done_seen);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/buckeye_shift_ctrl.md
Name: buckeye_shift_ctrl

Overview:
- Sequential controller that serially loads the configuration shift registers of NCHIPS Buckeye shaper ASICs on the DCFEB.
- Generates a per-chip shift clock (BKY_CLK) and shift data (TO_BKY) at a programmable divided rate.
- Captures the bits each chip shifts back out on BKY_RTN, so the previous contents are read back, and flags readback mismatches.
- Sits between the configuration/JTAG user register logic and the Buckeye pad buffers. The pad buffers stay outside this block.

Parameters:
- NCHIPS, 6: number of Buckeye chips, one lane each.
- NBITS, 48: shift-register length per chip (16 channels x 3 bits).
- CLK_DIV, 4: length of each BKY_CLK phase (low or high) in CLK cycles. Minimum 1.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request to begin a shift cycle. Sampled only in IDLE.
- CHIP_MASK  in  NCHIPS  1 = lane enabled. Latched at START.
- DIN  in  NCHIPS*NBITS  data to load. Lane k uses bits [k*NBITS +: NBITS]. Latched at START.
- BKY_RTN  in  NCHIPS  serial data returned from each chip.
- TO_BKY  out  NCHIPS  serial data to each chip.
- BKY_CLK  out  NCHIPS  shift clock to each chip.
- DOUT  out  NCHIPS*NBITS  captured readback, lane slices the same as DIN.
- BUSY  out  1  high while a shift cycle is in progress.
- DONE  out  1  one-cycle pulse when a shift cycle completes.
- CMP_ERR  out  NCHIPS  per lane: captured DOUT slice differs from the latched DIN slice.

Behaviour:
- Reset: the next CLK edge with RST=1 forces the FSM to IDLE. All outputs go to 0, including DOUT and CMP_ERR. All counters clear. RST mid-shift aborts immediately: BKY_CLK drops low with no further edges, and DONE is not pulsed.
- FSM states: IDLE, LOW, HIGH, FINISH.
- IDLE -> LOW on START=1. On that edge the block:
  - latches CHIP_MASK and DIN into the per-lane shift registers;
  - clears the capture registers;
  - sets BUSY=1 and bit_cnt=0.
- LOW phase, CLK_DIV cycles:
  - BKY_CLK=0.
  - TO_BKY[k] = MSB of lane k's shift register. Bits go out MSB-first: DIN slice bit NBITS-1 first.
- LOW -> HIGH on the edge that ends the low phase. On that same edge:
  - BKY_CLK goes 1;
  - BKY_RTN[k] is shifted into the LSB of capture register k;
  - the data shift register shifts left by one.
- HIGH phase, CLK_DIV cycles: BKY_CLK=1 and TO_BKY is held stable.
- At the end of HIGH, bit_cnt increments:
  - if bit_cnt == NBITS-1, go to FINISH;
  - otherwise go to LOW.
- FINISH, 1 cycle:
  - BKY_CLK=0, TO_BKY=0;
  - capture registers are copied to DOUT;
  - CMP_ERR[k] = enabled[k] & (capture_k != latched DIN_k);
  - DONE=1 for this cycle;
  - BUSY falls on the next edge, and the FSM returns to IDLE.
- Latency: START edge to DONE is exactly 2*CLK_DIV*NBITS + 1 cycles. BUSY is high for 2*CLK_DIV*NBITS + 1 cycles.
- Masked lanes:
  - BKY_CLK and TO_BKY are held 0 for the whole cycle;
  - their DOUT slice is 0 and their CMP_ERR bit is 0.
- START while BUSY is ignored, with no queuing. START in the same cycle as RST is ignored.
- CHIP_MASK or DIN changes during BUSY have no effect.
- CHIP_MASK = all zeros still runs the full timing (BUSY, then DONE), with no clock activity on any lane.
- DOUT and CMP_ERR hold their values until the next FINISH or RST.
- The phase counter is clog2(CLK_DIV) bits wide, minimum 1. bit_cnt is clog2(NBITS) bits wide and never wraps: it is cleared at START.
- All outputs are registered; there is no combinational path from an input to an output.

Decomposition:
- Package bky_pkg holds:
  - default constants BKY_NCHIPS=6, BKY_NBITS=48, BKY_CLK_DIV=4;
  - the FSM state enumeration;
  - the helper for the counter width.
- One sub-module, bky_phase_timer, built from CLK, RST and CLK_DIV:
  - counts the phase length;
  - issues a phase_end strobe;
  - is restarted by the FSM at START.
- The per-lane shift and capture registers are a generate loop in the top module, not separate modules.

Test Plan:
- Basic load: NCHIPS=6, NBITS=48, CLK_DIV=2; DIN lane k = 48'hA5A5_0000_0000 + k; mask 6'h3F; loop each TO_BKY back to BKY_RTN through a 48-bit model register preloaded with 0. Required: DONE exactly 193 cycles after START; 48 rising BKY_CLK edges per lane; DOUT all 0; CMP_ERR=6'h3F. Repeat START with the same DIN: DOUT equals DIN and CMP_ERR=0.
- Bit timing: CLK_DIV=3, DIN lane0 = 48'h8000_0000_0001. Required: each BKY_CLK low and high phase lasts 3 cycles; TO_BKY[0]=1 during the first and last bits only; TO_BKY is stable during every high phase.
- Masking: CHIP_MASK=6'b010101. Required: lanes 1, 3 and 5 have BKY_CLK/TO_BKY constantly 0, DOUT slice 0 and CMP_ERR bit 0. Lanes 0, 2 and 4 behave as in the basic-load scenario.
- START while busy: pulse START again at cycle 10 with a different DIN. Required: it is ignored; exactly one DONE pulse; DOUT reflects the first shift only.
- Reset mid-shift: assert RST at cycle 50 for 1 cycle. Required: on the next edge BUSY=0, BKY_CLK=0, DOUT=0, CMP_ERR=0, and no DONE pulse. A new START afterwards completes normally.
- Zero mask: CHIP_MASK=0, CLK_DIV=1. Required: BUSY for 97 cycles, DONE pulses, and no BKY_CLK edges on any lane.
